// File: rtl/cpu_mc_if.sv
// Instruction fetch port: one request/response pair, at most one request outstanding.
interface cpu_mc_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (output req_valid, output addr,
                  input  req_ready, input rsp_valid, input rsp_data);
  modport slave  (input  req_valid, input addr,
                  output req_ready, output rsp_valid, output rsp_data);
endinterface

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle RV32I/RV32E core retiring ADDI/ADD/LUI/AUIPC/JAL/JALR/EBREAK.
// Define CPU_COMMIT_EN to add the registered retirement trace ports (commit_*).
//
// state  | meaning
// S_REQ  | fetch request driven at pc, held until accepted
// S_WAIT | request accepted, waiting for the instruction word
// S_EXEC | decode/execute/writeback of ir, one cycle
// S_HALT | stopped by EBREAK or illegal instruction, left only by reset
module cpu_mc #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          NR_REGS  = 32,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  cpu_mc_if.master         imem,
  output logic             halt,
  output logic [31:0]      halt_code,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
`ifdef CPU_COMMIT_EN
  ,
  output logic             commit_valid,
  output logic [31:0]      commit_pc,
  output logic [31:0]      commit_insn,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_wdata
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_EXEC, S_HALT} state_t;

  localparam int                IDX_W  = $clog2(NR_REGS);
  localparam logic [5:0]        NR_LIM = 6'(NR_REGS);
  localparam logic [IDX_W-1:0]  A0_IDX = IDX_W'(10);
  localparam logic [31:0]       EBREAK = 32'h0010_0073;

  state_t      state, state_d;
  logic [31:0] pc, ir;
  logic [31:0] gpr [NR_REGS];

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  logic        wr_en, is_ebreak, bad_op, use_rs1, use_rs2, bad_reg, exec_illegal;
  logic [31:0] wr_data, pc_next;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_u = {ir[31:12], 12'h000};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // Out-of-range indices alias into the array here but are trapped as illegal below.
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : gpr[rs1[IDX_W-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : gpr[rs2[IDX_W-1:0]];

  always_comb begin
    wr_en     = 1'b0;
    wr_data   = 32'd0;
    pc_next   = pc + 32'd4;
    is_ebreak = 1'b0;
    bad_op    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (opcode)
      7'b0010011: begin
        use_rs1 = 1'b1;
        wr_en   = 1'b1;
        wr_data = rs1_val + imm_i;
        bad_op  = (funct3 != 3'b000);
      end
      7'b0110011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        wr_en   = 1'b1;
        wr_data = rs1_val + rs2_val;
        bad_op  = (funct3 != 3'b000) || (funct7 != 7'b0000000);
      end
      7'b0110111: begin
        wr_en   = 1'b1;
        wr_data = imm_u;
      end
      7'b0010111: begin
        wr_en   = 1'b1;
        wr_data = pc + imm_u;
      end
      7'b1101111: begin
        wr_en   = 1'b1;
        wr_data = pc + 32'd4;
        pc_next = pc + imm_j;
      end
      7'b1100111: begin
        use_rs1 = 1'b1;
        wr_en   = 1'b1;
        wr_data = pc + 32'd4;
        pc_next = (rs1_val + imm_i) & ~32'd1;
        bad_op  = (funct3 != 3'b000);
      end
      7'b1110011: begin
        is_ebreak = (ir == EBREAK);
        bad_op    = (ir != EBREAK);
      end
      default: bad_op = 1'b1;
    endcase
  end

  assign bad_reg = (wr_en   && ({1'b0, rd}  >= NR_LIM)) ||
                   (use_rs1 && ({1'b0, rs1} >= NR_LIM)) ||
                   (use_rs2 && ({1'b0, rs2} >= NR_LIM));
  assign exec_illegal = bad_op || bad_reg;

  always_comb begin
    state_d = state;
    case (state)
      S_REQ:   if (imem.req_ready) state_d = S_WAIT;
      S_WAIT:  if (imem.rsp_valid) state_d = S_EXEC;
      S_EXEC:  state_d = (exec_illegal || is_ebreak) ? S_HALT : S_REQ;
      default: state_d = S_HALT;
    endcase
  end

  // Gated by rst so no request is visible during the reset cycle.
  assign imem.req_valid = (state == S_REQ) && rst;
  assign imem.addr      = pc;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_REQ;
    else      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= RESET_PC;
      ir        <= 32'd0;
      halt      <= 1'b0;
      halt_code <= 32'd0;
      illegal   <= 1'b0;
      retired   <= '0;
      for (int i = 0; i < NR_REGS; i++) gpr[i] <= 32'd0;
    end else begin
      if (state == S_WAIT && imem.rsp_valid) ir <= imem.rsp_data;
      if (state == S_EXEC) begin
        if (exec_illegal) begin
          halt      <= 1'b1;
          illegal   <= 1'b1;
          halt_code <= 32'hFFFF_FFFF;
        end else begin
          retired <= retired + CNT_W'(1);
          if (is_ebreak) begin
            halt      <= 1'b1;
            halt_code <= gpr[A0_IDX];
          end else begin
            pc <= pc_next;
          end
          if (wr_en && rd != 5'd0) gpr[rd[IDX_W-1:0]] <= wr_data;
        end
      end
    end
  end

`ifdef CPU_COMMIT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      commit_valid <= 1'b0;
      commit_pc    <= 32'd0;
      commit_insn  <= 32'd0;
      commit_rd    <= 5'd0;
      commit_wdata <= 32'd0;
    end else begin
      commit_valid <= (state == S_EXEC) && !exec_illegal;
      if (state == S_EXEC && !exec_illegal) begin
        commit_pc    <= pc;
        commit_insn  <= ir;
        commit_rd    <= (wr_en && rd != 5'd0) ? rd : 5'd0;
        commit_wdata <= (wr_en && rd != 5'd0) ? wr_data : 32'd0;
      end
    end
  end
`endif

endmodule
